vga_digit_sched: RTL and testbench

- Schedules updates of the 32-bit value shown by the VGA digit display.
- Arbitrates between two requesters (A: CPU MMIO store path, B: debug/switch path) with round-robin.
- Buffers one accepted value and commits it to the display register only on a frame boundary, derived from the display's vsync, so no frame shows a torn value.
- Enforces a minimum on-screen time per value. Sits in the CPU clock domain; its digit output drives the vga top's digit input.

---
 rtl/vga_digit_sched.sv | 170 +++++++++++++++++
 tb/tb_vga_digit_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_digit_sched.sv
// vga_digit_sched: picks one of two requesters round-robin, buffers the value,
// and commits it to the digit display only on a vsync-derived frame boundary.
// A committed value stays on screen for at least FRAME_HOLD+1 frames.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Requesters hold valid and data stable until they see ready. Ready is
// combinational from the valids and the current state, and at most one ready
// is high in any cycle.
module vga_digit_sched #(
    parameter int DATA_W     = 32,
    parameter int FRAME_HOLD = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [DATA_W-1:0] digit,
    output logic              digit_src,
    output logic              commit,
    output logic              pending,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [1:0]        dbg_state
);

    localparam int HOLD_W = (FRAME_HOLD > 0) ? $clog2(FRAME_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FRAME_HOLD);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic                w_frame_tick;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [DATA_W-1:0]   r_buf;
    logic                r_buf_src;
    logic                r_last_grant;   // 0 = A, 1 = B
    logic [DATA_W-1:0]   r_digit;
    logic                r_digit_src;
    logic                r_pending;
    logic                w_grant_a;
    logic                w_grant_b;
    logic                w_xfer;

    // Falling edge of the synchronised vsync marks a frame boundary.
    assign w_frame_tick = r_s3 & ~r_s2;

    // Round-robin: on a tie the requester that did not win last time goes.
    assign w_grant_a = a_valid && (!b_valid || r_last_grant);
    assign w_grant_b = b_valid && (!a_valid || !r_last_grant);
    assign w_xfer    = a_ready | b_ready;

    assign digit     = r_digit;
    assign digit_src = r_digit_src;
    assign pending   = r_pending;
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;

    // Two-flop synchroniser for vsync plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= vsync;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Count every frame boundary, wrapping silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: fill on transfer, commit on a boundary once the hold is spent.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY:  if (w_xfer) w_next_state = ST_FULL;
            ST_FULL:   if (w_frame_tick && (r_hold_cnt == '0)) w_next_state = ST_COMMIT;
            ST_COMMIT: w_next_state = ST_EMPTY;
            default:   w_next_state = ST_EMPTY;
        endcase
    end

    // Outputs decoded from state: readies only when the buffer is free.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        commit  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                a_ready = w_grant_a;
                b_ready = w_grant_b;
            end
            ST_COMMIT: commit = 1'b1;
            default: begin
                a_ready = 1'b0;
                b_ready = 1'b0;
            end
        endcase
    end

    // Capture the granted value and remember who won for the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf        <= '0;
            r_buf_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_buf        <= a_ready ? a_data : b_data;
            r_buf_src    <= b_ready;
            r_last_grant <= b_ready;
        end
    end

    // Display register, pending flag and the minimum-display hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit     <= '0;
            r_digit_src <= 1'b0;
            r_pending   <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            if (r_state == ST_COMMIT) begin
                r_digit     <= r_buf;
                r_digit_src <= r_buf_src;
                r_pending   <= 1'b0;
                r_hold_cnt  <= HOLD_INIT;
            end else begin
                if (w_xfer) begin
                    r_pending <= 1'b1;
                end
                // Idle and waiting frames both count toward the hold.
                if (w_frame_tick && (r_hold_cnt != '0)) begin
                    r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_digit_sched.sv
// Bench for vga_digit_sched: two instances (FRAME_HOLD=0/CNT_W=16 and
// FRAME_HOLD=2/CNT_W=6) run in lockstep against a frame-level reference model.
module tb_vga_digit_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        vsync, a_valid, b_valid, a_ready, b_ready;
    logic [1:0]        digit_src, commit, pending;
    logic [1:0][31:0]  a_data, b_data, digit;
    logic [15:0]       fc0;
    logic [5:0]        fc1;
    logic [1:0]        dbg0, dbg1;

    vga_digit_sched #(.DATA_W(32), .FRAME_HOLD(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .vsync(vsync[0]),
        .a_valid(a_valid[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
        .b_valid(b_valid[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
        .digit(digit[0]), .digit_src(digit_src[0]), .commit(commit[0]),
        .pending(pending[0]), .frame_cnt(fc0), .dbg_state(dbg0)
    );

    vga_digit_sched #(.DATA_W(32), .FRAME_HOLD(2), .CNT_W(6)) dut1 (
        .clk(clk), .rst(rst), .vsync(vsync[1]),
        .a_valid(a_valid[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
        .b_valid(b_valid[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
        .digit(digit[1]), .digit_src(digit_src[1]), .commit(commit[1]),
        .pending(pending[1]), .frame_cnt(fc1), .dbg_state(dbg1)
    );

    int n_checks = 0;
    int n_err    = 0;

    // requester queues: head is the value currently offered
    logic [31:0] aq0[$], aq1[$], bq0[$], bq1[$];
    logic [1:0]  vs_lvl;

    // reference model: frame-level view of each instance
    logic [2:0]  m_hist[2];     // last three vsync samples, [0] newest
    bit          m_full[2];     // value waiting for a boundary
    bit          m_comm[2];     // boundary qualified, value lands next edge
    bit          m_bsrc[2], m_src[2], m_last[2];
    logic [31:0] m_buf[2], m_digit[2];
    int          m_fcnt[2], m_since[2];

    function automatic int hold_of(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int fmask(int i);
        return (i == 0) ? 65535 : 63;
    endfunction

    function automatic logic [31:0] get_fc(int i);
        return (i == 0) ? {16'b0, fc0} : {26'b0, fc1};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hist[i]  = 3'b111;
            m_full[i]  = 0;
            m_comm[i]  = 0;
            m_bsrc[i]  = 0;
            m_src[i]   = 0;
            m_last[i]  = 1;
            m_buf[i]   = '0;
            m_digit[i] = '0;
            m_fcnt[i]  = 0;
            m_since[i] = hold_of(i);
        end
    endtask

    task automatic drive_inputs();
        a_valid[0] = (aq0.size() != 0);
        a_data[0]  = a_valid[0] ? aq0[0] : $urandom;
        b_valid[0] = (bq0.size() != 0);
        b_data[0]  = b_valid[0] ? bq0[0] : $urandom;
        a_valid[1] = (aq1.size() != 0);
        a_data[1]  = a_valid[1] ? aq1[0] : $urandom;
        b_valid[1] = (bq1.size() != 0);
        b_data[1]  = b_valid[1] ? bq1[0] : $urandom;
        vsync      = vs_lvl;
    endtask

    task automatic do_reset();
        aq0.delete(); aq1.delete(); bq0.delete(); bq1.delete();
        vs_lvl = 2'b11;
        rst = 1'b1;
        drive_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // one clock: drive, compare against the model, advance model and requesters
    task automatic step();
        bit tk, emp, ea, eb;
        bit ra[2], rb[2];
        logic [31:0] dummy;
        drive_inputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            tk  = m_hist[i][2] & ~m_hist[i][1];
            emp = !m_full[i] && !m_comm[i];
            ea  = emp && a_valid[i] && (!b_valid[i] || m_last[i]);
            eb  = emp && b_valid[i] && (!a_valid[i] || !m_last[i]);
            chk($sformatf("a_ready[%0d]", i), 32'(a_ready[i]), 32'(ea));
            chk($sformatf("b_ready[%0d]", i), 32'(b_ready[i]), 32'(eb));
            chk($sformatf("commit[%0d]", i), 32'(commit[i]), 32'(m_comm[i]));
            chk($sformatf("pending[%0d]", i), 32'(pending[i]), 32'(m_full[i] | m_comm[i]));
            chk($sformatf("digit[%0d]", i), digit[i], m_digit[i]);
            chk($sformatf("digit_src[%0d]", i), 32'(digit_src[i]), 32'(m_src[i]));
            chk($sformatf("frame_cnt[%0d]", i), get_fc(i), 32'(m_fcnt[i]));
            ra[i] = a_ready[i];
            rb[i] = b_ready[i];
            // advance the model by one edge
            if (tk) m_fcnt[i] = (m_fcnt[i] + 1) & fmask(i);
            if (m_comm[i]) begin
                m_digit[i] = m_buf[i];
                m_src[i]   = m_bsrc[i];
                m_comm[i]  = 0;
                m_since[i] = 0;
            end else if (m_full[i]) begin
                if (tk) begin
                    if (m_since[i] >= hold_of(i)) begin
                        m_full[i] = 0;
                        m_comm[i] = 1;
                    end else begin
                        m_since[i]++;
                    end
                end
            end else begin
                if (tk && m_since[i] < hold_of(i)) m_since[i]++;
                if (ea || eb) begin
                    m_full[i] = 1;
                    m_buf[i]  = ea ? a_data[i] : b_data[i];
                    m_bsrc[i] = eb;
                    m_last[i] = eb;
                end
            end
            m_hist[i] = {m_hist[i][1:0], vsync[i]};
        end
        @(posedge clk);
        if (ra[0] && aq0.size() != 0) dummy = aq0.pop_front();
        if (rb[0] && bq0.size() != 0) dummy = bq0.pop_front();
        if (ra[1] && aq1.size() != 0) dummy = aq1.pop_front();
        if (rb[1] && bq1.size() != 0) dummy = bq1.pop_front();
        @(negedge clk);
    endtask

    task automatic pulse(int i, int lo, int hi);
        vs_lvl[i] = 1'b0;
        repeat (lo) step();
        vs_lvl[i] = 1'b1;
        repeat (hi) step();
    endtask

    typedef struct {
        bit          do_rst;
        bit          pa;
        bit          pb;
        logic [31:0] da;
        logic [31:0] db;
        bit          vs;
        int          n;
        logic [31:0] e_digit;
        bit          e_src;
        bit          e_pend;
        int          e_fcnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_left[2];
        // single A write, then two simultaneous requesters (A wins first)
        tbl[0] = '{1, 1, 0, 32'h12345678, 32'h0, 1, 3, 32'h0,        0, 1, 0};
        tbl[1] = '{0, 0, 0, 32'h0,        32'h0, 0, 4, 32'h12345678, 0, 0, 1};
        tbl[2] = '{0, 0, 0, 32'h0,        32'h0, 1, 6, 32'h12345678, 0, 0, 1};
        tbl[3] = '{1, 1, 1, 32'h1,        32'h2, 1, 2, 32'h0,        0, 1, 0};
        tbl[4] = '{0, 0, 0, 32'h0,        32'h0, 0, 4, 32'h1,        0, 0, 1};
        tbl[5] = '{0, 0, 0, 32'h0,        32'h0, 1, 2, 32'h1,        0, 1, 1};
        tbl[6] = '{0, 0, 0, 32'h0,        32'h0, 0, 4, 32'h2,        1, 0, 2};
        tbl[7] = '{0, 0, 0, 32'h0,        32'h0, 1, 4, 32'h2,        1, 0, 2};

        rst = 1'b1;
        vs_lvl = 2'b11;
        drive_inputs();
        @(negedge clk);
        do_reset();
        chk("reset digit", digit[0], 32'h0);
        chk("reset pending", 32'(pending[0]), 32'h0);
        chk("reset frame_cnt", get_fc(0), 32'h0);

        // table-driven scenarios on the FRAME_HOLD=0 instance
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].do_rst) do_reset();
            if (tbl[k].pa) aq0.push_back(tbl[k].da);
            if (tbl[k].pb) bq0.push_back(tbl[k].db);
            vs_lvl[0] = tbl[k].vs;
            repeat (tbl[k].n) step();
            chk($sformatf("tbl%0d digit", k), digit[0], tbl[k].e_digit);
            chk($sformatf("tbl%0d src", k), 32'(digit_src[0]), 32'(tbl[k].e_src));
            chk($sformatf("tbl%0d pending", k), 32'(pending[0]), 32'(tbl[k].e_pend));
            chk($sformatf("tbl%0d frame_cnt", k), get_fc(0), 32'(tbl[k].e_fcnt));
        end

        // FRAME_HOLD=2: 0xA at frame 1, 0xB only at frame 4
        do_reset();
        aq1.push_back(32'hA);
        aq1.push_back(32'hB);
        repeat (3) step();
        for (int f = 1; f <= 4; f++) begin
            pulse(1, 2, 8);
            chk($sformatf("hold f%0d digit", f), digit[1], (f < 4) ? 32'hA : 32'hB);
            chk($sformatf("hold f%0d frame_cnt", f), get_fc(1), 32'(f));
        end

        // vsync falls while the COMMIT cycle is active
        do_reset();
        aq0.push_back(32'h55);
        repeat (2) step();
        vs_lvl[0] = 0; step();
        vs_lvl[0] = 1; step(); step();
        vs_lvl[0] = 0; step(); step();
        vs_lvl[0] = 1; repeat (6) step();
        chk("vs_in_commit frame_cnt", get_fc(0), 32'd2);
        chk("vs_in_commit digit", digit[0], 32'h55);
        chk("vs_in_commit pending", 32'(pending[0]), 32'h0);

        // asynchronous reset while a value is waiting
        do_reset();
        aq0.push_back(32'h77);
        step();
        pulse(0, 2, 6);
        aq0.push_back(32'hDEAD);
        repeat (2) step();
        chk("pre_rst pending", 32'(pending[0]), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst digit", digit[0], 32'h0);
        chk("async_rst pending", 32'(pending[0]), 32'h0);
        chk("async_rst frame_cnt", get_fc(0), 32'h0);
        chk("async_rst commit", 32'(commit[0]), 32'h0);
        aq0.delete(); aq1.delete(); bq0.delete(); bq1.delete();
        drive_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pulse(0, 2, 6);
        chk("post_rst pending", 32'(pending[0]), 32'h0);
        chk("post_rst digit", digit[0], 32'h0);

        // frame counter wrap on the CNT_W=6 instance, with commits in flight
        do_reset();
        for (int v = 0; v < 5; v++) aq1.push_back($urandom);
        for (int p = 0; p < 63; p++) pulse(1, 2, 2);
        chk("wrap frame_cnt 63", get_fc(1), 32'd63);
        pulse(1, 2, 2);
        chk("wrap frame_cnt 0", get_fc(1), 32'd0);

        // randomized traffic and vsync timing on both instances
        do_reset();
        run_left[0] = 5;
        run_left[1] = 7;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if ($urandom_range(0, 3) == 0 && aq0.size() < 3) aq0.push_back($urandom);
            if ($urandom_range(0, 3) == 0 && bq0.size() < 3) bq0.push_back($urandom);
            if ($urandom_range(0, 3) == 0 && aq1.size() < 3) aq1.push_back($urandom);
            if ($urandom_range(0, 3) == 0 && bq1.size() < 3) bq1.push_back($urandom);
            for (int i = 0; i < 2; i++) begin
                if (run_left[i] == 0) begin
                    vs_lvl[i]   = ~vs_lvl[i];
                    run_left[i] = vs_lvl[i] ? $urandom_range(1, 25) : $urandom_range(1, 3);
                end else begin
                    run_left[i]--;
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
